// File: rtl/fnd_scan_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fnd_scan_controller                                              |
// | Purpose  : Converts a 14-bit binary value to four BCD digits with a         |
// |            sequential shift-add-3 engine and time-multiplexes the digits    |
// |            for a 4-digit FND at a programmable refresh rate.                |
// | Options  : FND_LEADING_BLANK_EN - blank leading zero digits (digit 0 is     |
// |            never blanked). Undefined: all four digits always shown.         |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_bcd,
  output logic        o_digitEn,
  output logic        o_busy,
  output logic        o_ovf
);

  localparam int                TICK_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [13:0]       MAX_VALUE = 14'd9999;
  localparam logic [3:0]        LAST_BIT  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [13:0]       shift_q, shift_d;
  logic [15:0]       acc_q,   acc_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic [15:0]       disp_q,  disp_d;
  logic              ovf_q,   ovf_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [1:0]        sel_q,   sel_d;

  logic [15:0]       w_adj;
  logic              w_en;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next doubling
  function automatic logic [15:0] add3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int n = 0; n < 4; n++) begin
      if (a[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = a[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign w_adj = add3(acc_q);

  // Converter: capture clamped value, run 14 add-3/shift steps, publish result
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          shift_d = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
          ovf_d   = (i_value > MAX_VALUE);
          acc_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // {accumulator, shift register} shifted left by one after the adjust
        acc_d   = {w_adj[14:0], shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Whole display word changes in one edge so digits never mix values
        disp_d  = acc_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scanner: free-running tick divider, digit slot advances on each wrap
  always_comb begin
    tick_d = tick_q + 1'b1;
    sel_d  = sel_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      sel_d  = sel_q + 2'd1;
    end
  end

  // State registers; reset also discards any conversion in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      shift_q <= 14'd0;
      acc_q   <= 16'd0;
      cnt_q   <= 4'd0;
      disp_q  <= 16'd0;
      ovf_q   <= 1'b0;
      tick_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
    end
  end

`ifdef FND_LEADING_BLANK_EN
  // Slot is shown if it is digit 0 or any digit at or above it is non-zero
  always_comb begin
    w_en = 1'b1;
    case (sel_q)
      2'd0:    w_en = 1'b1;
      2'd1:    w_en = |disp_q[15:4];
      2'd2:    w_en = |disp_q[15:8];
      2'd3:    w_en = |disp_q[15:12];
      default: w_en = 1'b1;
    endcase
  end
`else
  assign w_en = 1'b1;
`endif

  // Outputs depend on registers only, never directly on inputs
  assign o_digitSelect = sel_q;
  assign o_bcd         = disp_q[{sel_q, 2'b00} +: 4];
  assign o_digitEn     = w_en;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fnd_scan_controller                                           |
// | Purpose  : Self-checking bench for fnd_scan_controller (SCAN_DIV = 4).      |
// |            Decimal-arithmetic reference model compared every cycle, plus    |
// |            directed scenarios with literal expectations.                    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;
`ifdef FND_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [13:0] i_value = 14'd0;
  logic        i_load = 1'b0;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_bcd;
  logic        o_digitEn;
  logic        o_busy;
  logic        o_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_value      (i_value),
    .i_load       (i_load),
    .o_digitSelect(o_digitSelect),
    .o_bcd        (o_bcd),
    .o_digitEn    (o_digitEn),
    .o_busy       (o_busy),
    .o_ovf        (o_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: decimal display value, busy countdown, edges since reset
  int m_disp  = 0;
  int m_pend  = 0;
  int m_rem   = 0;
  int m_k     = 0;
  bit m_ovf   = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_disp  = 0;
      m_rem   = 0;
      m_k     = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_k = m_k + 1;
      if (m_rem == 0) begin
        if (i_load) begin
          m_rem  = 15;
          m_pend = (int'(i_value) > 9999) ? 9999 : int'(i_value);
          m_ovf  = (int'(i_value) > 9999);
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_disp = m_pend;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int s;
    int en;
    if (m_valid) begin
      s  = (m_k / SCAN_DIV) % 4;
      en = BLANK ? int'(s == 0 || m_disp >= pow10(s)) : 1;
      chk("model_sel",  int'(o_digitSelect), s);
      chk("model_bcd",  int'(o_bcd), (m_disp / pow10(s)) % 10);
      chk("model_en",   int'(o_digitEn), en);
      chk("model_busy", int'(o_busy), int'(m_rem > 0));
      chk("model_ovf",  int'(o_ovf), int'(m_ovf));
    end
  end

  task automatic do_load(input int v);
    @(posedge clk); #1;
    i_value = v[13:0];
    i_load  = 1'b1;
    @(posedge clk); #1;
    i_load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) chk("idle_timeout", int'(o_busy), 0);
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    @(negedge clk);
    while (int'(o_digitSelect) != s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (int'(o_digitSelect) != s) chk("slot_timeout", int'(o_digitSelect), s);
  endtask

  // Literal per-slot digits; en_mask bit s = expected o_digitEn in slot s
  task automatic check_digits(input string tag, input int d0, input int d1,
                              input int d2, input int d3, input logic [3:0] en_mask);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int s = 0; s < 4; s++) begin
      wait_slot(s);
      chk({tag, "_bcd"}, int'(o_bcd), d[s]);
      chk({tag, "_en"},  int'(o_digitEn), BLANK ? int'(en_mask[s]) : 1);
    end
  endtask

  initial begin
    int sel_lit[20];
    int busy_cnt;
    sel_lit = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0};

    // Reset, then 20 idle cycles
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_sel",  int'(o_digitSelect), sel_lit[i]);
      chk("hold_bcd",  int'(o_bcd), 0);
      chk("hold_busy", int'(o_busy), 0);
      chk("hold_ovf",  int'(o_ovf), 0);
    end

    // 1234: busy exactly 15 cycles
    do_load(1234);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      busy_cnt++;
    end
    chk("busy_len_1234", busy_cnt, 15);
    check_digits("v1234", 4, 3, 2, 1, 4'b1111);

    // Overflow clamps to 9999, next load clears the flag
    do_load(12000);
    wait_idle();
    chk("ovf_12000", int'(o_ovf), 1);
    check_digits("v12000", 9, 9, 9, 9, 4'b1111);
    do_load(5);
    wait_idle();
    chk("ovf_5", int'(o_ovf), 0);
    check_digits("v5", 5, 0, 0, 0, 4'b0001);

    // Load during conversion is ignored
    do_load(42);
    repeat (4) @(posedge clk);
    do_load(77);
    wait_idle();
    check_digits("v42", 2, 4, 0, 0, 4'b0011);

    // Reset mid-conversion aborts and clears the display
    do_load(9999);
    repeat (6) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("rst_sel",  int'(o_digitSelect), 0);
    chk("rst_bcd",  int'(o_bcd), 0);
    chk("rst_en",   int'(o_digitEn), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovf",  int'(o_ovf), 0);
    repeat (20) @(posedge clk);
    chk("rst_stay_busy", int'(o_busy), 0);
    check_digits("after_rst", 0, 0, 0, 0, 4'b0001);

    // Zero: only digit 0 shown when blanking is enabled
    do_load(0);
    wait_idle();
    check_digits("v0", 0, 0, 0, 0, 4'b0001);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got running, expected finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
